// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state type and constants for the UART receive controller
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} rx_state_t;
  localparam int PRESCALE_8 = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;
  localparam logic [3:0] STRT_BIT_IDX = 4'd0;
endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversample tick counter wrapping at prescale, with bit index
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [PW-1:0] prescale,
  output logic [PW-1:0] edge_cnt,
  output logic [3:0]    bit_cnt
);
  logic [PW-1:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic wrap;
  always_comb begin
    wrap = edge_q == prescale - PW'(1);
    edge_d = !en ? '0 : ld ? PW'(1) : wrap ? '0 : edge_q + PW'(1);
    bit_d = !en ? '0 : ld ? STRT_BIT_IDX : wrap ? bit_q + 4'd1 : bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      bit_q <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q <= bit_d;
    end
  end
  assign edge_cnt = edge_q;
  assign bit_cnt = bit_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving stage enables, checker clear and the frame-valid strobe
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      deser_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      error_rst,
  output logic                      data_valid
);
  localparam int PW = PRESCALE_WIDTH;
  rx_state_t state_q, state_d;
  logic [PW-1:0] prescale_q, prescale_d, en_edge;
  logic par_en_q, par_en_d, bit_end, latch, cnt_en, cnt_ld;
  logic active_q, active_d, strt_q, strt_d, deser_q, deser_d;
  logic par_q, par_d, stp_q, stp_d, valid_q, valid_d;
  uart_rx_edge_bit_counter #(.PW(PW)) u_cnt (
    .clk(CLK),
    .rst(RST),
    .en(cnt_en),
    .ld(cnt_ld),
    .prescale(prescale_q),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt)
  );
  always_comb begin
    bit_end = edge_cnt == prescale_q - PW'(1);
    en_edge = (prescale_q >> 1) + PW'(1);
    latch = state_q == IDLE || state_q == DONE;
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (RX_IN) state_d = IDLE; else state_d = START;
      START: if (bit_end && strt_glitch) state_d = IDLE; else if (bit_end) state_d = DATA;
      DATA: if (bit_end && bit_cnt == 4'(DATA_WIDTH) && par_en_q) state_d = PARITY;
            else if (bit_end && bit_cnt == 4'(DATA_WIDTH)) state_d = STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
    cnt_en = state_q != IDLE && state_d != IDLE;
    cnt_ld = state_q == DONE && state_d == START;
    prescale_d = latch ? PRESCALE : prescale_q;
    par_en_d = latch ? PAR_EN : par_en_q;
    active_d = state_d != IDLE && state_d != DONE;
    strt_d = state_q == START && edge_cnt == en_edge;
    deser_d = state_q == DATA && edge_cnt == en_edge;
    par_d = state_q == PARITY && edge_cnt == en_edge;
    stp_d = state_q == STOP && edge_cnt == en_edge;
    valid_d = state_d == DONE && !stp_err && !(par_en_q && par_err);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      prescale_q <= '0;
      par_en_q <= 1'b0;
      active_q <= 1'b0;
      strt_q <= 1'b0;
      deser_q <= 1'b0;
      par_q <= 1'b0;
      stp_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prescale_q <= prescale_d;
      par_en_q <= par_en_d;
      active_q <= active_d;
      strt_q <= strt_d;
      deser_q <= deser_d;
      par_q <= par_d;
      stp_q <= stp_d;
      valid_q <= valid_d;
    end
  end
  assign dat_samp_en = active_q;
  assign error_rst = active_q;
  assign strt_chk_en = strt_q;
  assign deser_en = deser_q;
  assign par_chk_en = par_q;
  assign stp_chk_en = stp_q;
  assign data_valid = valid_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame vectors against the UART receive sequencer with modelled checkers
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;
  typedef struct {
    logic [7:0] d;
    bit pe;
    bit par_bad;
    bit stop_bit;
    bit fpar;
    int p;
    bit exp_dv;
    int exp_lat;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic strt_glitch, par_err, stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, error_rst, data_valid;
  logic glitch_m = 1'b0, par_m = 1'b0, stp_m = 1'b0, force_par = 1'b0, dv_prev = 1'b0;
  logic [7:0] data_sh = 8'h00;
  int cyc = 0, cur_p = 8, n_chk = 0, n_pass = 0, last_start = 0;
  int n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0, n_bad_edge = 0;
  int dv_cycs[$], post_edges[$], post_bits[$];
  vec_t vecs[7];
  uart_rx_ctrl dut (
    .CLK(clk),
    .RST(rst),
    .RX_IN(rx),
    .PAR_EN(par_en),
    .PRESCALE(prescale),
    .strt_glitch(strt_glitch),
    .par_err(par_err),
    .stp_err(stp_err),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en),
    .deser_en(deser_en),
    .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en),
    .error_rst(error_rst),
    .data_valid(data_valid)
  );
  always #5 clk = ~clk;
  assign strt_glitch = glitch_m;
  assign par_err = par_m | force_par;
  assign stp_err = stp_m;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (deser_en) data_sh <= {rx, data_sh[7:1]};
    glitch_m <= !error_rst ? 1'b0 : strt_chk_en ? rx : glitch_m;
    par_m <= !error_rst ? 1'b0 : par_chk_en ? rx ^ (^data_sh) : par_m;
    stp_m <= !error_rst ? 1'b0 : stp_chk_en ? !rx : stp_m;
  end
  always @(negedge clk) begin
    if (dv_prev) begin
      post_edges.push_back(int'(edge_cnt));
      post_bits.push_back(int'(bit_cnt));
    end
    dv_prev = data_valid;
    if (data_valid) dv_cycs.push_back(cyc);
    if ((strt_chk_en | deser_en | par_chk_en | stp_chk_en) && int'(edge_cnt) != cur_p / 2 + 2) n_bad_edge++;
    if (strt_chk_en) n_strt++;
    if (deser_en) n_deser++;
    if (par_chk_en) n_par++;
    if (stp_chk_en) n_stp++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit par_bit, input bit stop_bit, input int p);
    logic [10:0] bits;
    int nb;
    bits = pe ? {stop_bit, par_bit, d, 1'b0} : {1'b1, stop_bit, d, 1'b0};
    nb = pe ? 11 : 10;
    prescale = 6'(p);
    par_en = pe;
    cur_p = p;
    last_start = cyc;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      repeat (p) tick();
      if (i == 0) begin
        prescale = (p == PRESCALE_16) ? 6'd8 : 6'd16;
        par_en = !pe;
      end
    end
    rx = 1'b1;
  endtask
  task automatic run_vec(input vec_t v, input int k);
    int n0, s0, d0, p0, t0, b0;
    n0 = dv_cycs.size();
    s0 = n_strt;
    d0 = n_deser;
    p0 = n_par;
    t0 = n_stp;
    b0 = n_bad_edge;
    force_par = v.fpar;
    send_frame(v.d, v.pe, (^v.d) ^ v.par_bad, v.stop_bit, v.p);
    tick();
    chk($sformatf("v%0d done data_valid", k), int'(data_valid), int'(v.exp_dv));
    chk($sformatf("v%0d done error_rst", k), int'(error_rst), 0);
    chk($sformatf("v%0d done stp_err", k), int'(stp_err), int'(!v.stop_bit));
    chk($sformatf("v%0d done bit_cnt", k), int'(bit_cnt), v.pe ? 11 : 10);
    tick();
    chk($sformatf("v%0d idle stp_err", k), int'(stp_err), 0);
    chk($sformatf("v%0d idle edge_cnt", k), int'(edge_cnt), 0);
    chk($sformatf("v%0d idle dat_samp_en", k), int'(dat_samp_en), 0);
    force_par = 1'b0;
    repeat (2) tick();
    chk($sformatf("v%0d valid pulses", k), dv_cycs.size() - n0, int'(v.exp_dv));
    if (v.exp_dv && dv_cycs.size() > n0) chk($sformatf("v%0d latency", k), dv_cycs[$] - last_start, v.exp_lat);
    chk($sformatf("v%0d strt pulses", k), n_strt - s0, 1);
    chk($sformatf("v%0d deser pulses", k), n_deser - d0, 8);
    chk($sformatf("v%0d par pulses", k), n_par - p0, int'(v.pe));
    chk($sformatf("v%0d stp pulses", k), n_stp - t0, 1);
    chk($sformatf("v%0d enable edge", k), n_bad_edge - b0, 0);
    chk($sformatf("v%0d data", k), int'(data_sh), int'(v.d));
  endtask
  initial begin
    int n0, s0, d0, p0, t0, sc;
    logic [7:0] rb;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, PRESCALE_8, 1'b1, 89};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, PRESCALE_16, 1'b0, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, PRESCALE_16, 1'b1, 161};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, PRESCALE_8, 1'b0, 0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, PRESCALE_8, 1'b1, 81};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, PRESCALE_32, 1'b1, 353};
    vecs[6] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, PRESCALE_16, 1'b0, 0};
    repeat (3) tick();
    chk("reset edge_cnt", int'(edge_cnt), 0);
    chk("reset bit_cnt", int'(bit_cnt), 0);
    chk("reset flags", int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, error_rst, data_valid}), 0);
    rst = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);
    n0 = dv_cycs.size();
    s0 = n_strt;
    d0 = n_deser;
    p0 = n_par;
    t0 = n_stp;
    prescale = 6'd16;
    par_en = 1'b0;
    cur_p = 16;
    rx = 1'b0;
    sc = cyc;
    repeat (3) tick();
    rx = 1'b1;
    repeat (13) tick();
    chk("glitch last tick edge_cnt", int'(edge_cnt), 15);
    chk("glitch last tick dat_samp_en", int'(dat_samp_en), 1);
    tick();
    chk("glitch cycle count", cyc - sc, 17);
    chk("glitch idle edge_cnt", int'(edge_cnt), 0);
    chk("glitch idle dat_samp_en", int'(dat_samp_en), 0);
    chk("glitch idle error_rst", int'(error_rst), 0);
    repeat (20) tick();
    chk("glitch strt pulses", n_strt - s0, 1);
    chk("glitch other pulses", (n_deser - d0) + (n_par - p0) + (n_stp - t0), 0);
    chk("glitch valid pulses", dv_cycs.size() - n0, 0);
    n0 = dv_cycs.size();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, PRESCALE_32);
    sc = last_start;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, PRESCALE_32);
    repeat (4) tick();
    chk("b2b valid pulses", dv_cycs.size() - n0, 2);
    if (dv_cycs.size() >= n0 + 2 && post_edges.size() >= n0 + 1) begin
      chk("b2b first latency", dv_cycs[n0] - sc, 321);
      chk("b2b spacing", dv_cycs[n0 + 1] - dv_cycs[n0], 320);
      chk("b2b restart edge_cnt", post_edges[n0], 1);
      chk("b2b restart bit_cnt", post_bits[n0], int'(STRT_BIT_IDX));
    end
    chk("b2b data", int'(data_sh), 8'hC3);
    repeat (3) tick();
    n0 = dv_cycs.size();
    rb = 8'hA5;
    prescale = 6'd8;
    par_en = 1'b1;
    cur_p = 8;
    rx = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      rx = rb[i];
      repeat (8) tick();
    end
    rx = rb[3];
    repeat (3) tick();
    chk("pre-reset bit_cnt", int'(bit_cnt), 4);
    chk("pre-reset edge_cnt", int'(edge_cnt), 2);
    rst = 1'b1;
    rx = 1'b1;
    tick();
    chk("mid reset edge_cnt", int'(edge_cnt), 0);
    chk("mid reset bit_cnt", int'(bit_cnt), 0);
    chk("mid reset flags", int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, error_rst, data_valid}), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("aborted frame valid pulses", dv_cycs.size() - n0, 0);
    run_vec(vecs[0], 7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
